pe_elastic_alu: RTL and testbench

//  Next-generation PE compute BEL: parametrised-width ALU with elastic valid/ready operand channels

---
 rtl/pe_pkg.sv | 33 +++
 rtl/pe_elastic_fifo.sv | 38 +++
 rtl/pe_elastic_alu.sv | 84 ++++++++
 tb/tb_pe_elastic_alu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared PE op encodings, source-select constant and the common ALU function.
package pe_pkg;
  localparam int PE_NUM_DIRS = 4;
  localparam int SRC_CONST = PE_NUM_DIRS;
  localparam int PE_MAX_W = 64;
  typedef logic [PE_MAX_W-1:0] pe_word_t;
  typedef enum logic [2:0] {
    PE_OP_ADD  = 3'd0,
    PE_OP_SUB  = 3'd1,
    PE_OP_MUL  = 3'd2,
    PE_OP_AND  = 3'd3,
    PE_OP_OR   = 3'd4,
    PE_OP_XOR  = 3'd5,
    PE_OP_SHL  = 3'd6,
    PE_OP_PASS = 3'd7
  } pe_op_t;
  // Operands arrive zero-extended; callers keep their low bits and pass log2 of their width as sh_w.
  function automatic pe_word_t pe_alu(input pe_op_t op, input pe_word_t a, input pe_word_t b,
                                      input int unsigned sh_w);
    pe_word_t sh_mask;
    sh_mask = (pe_word_t'(1) << sh_w) - pe_word_t'(1);
    case (op)
      PE_OP_ADD: return a + b;
      PE_OP_SUB: return a - b;
      PE_OP_MUL: return a * b;
      PE_OP_AND: return a & b;
      PE_OP_OR:  return a | b;
      PE_OP_XOR: return a ^ b;
      PE_OP_SHL: return a << (b & sh_mask);
      default:   return a;
    endcase
  endfunction
endpackage

// File: rtl/pe_elastic_fifo.sv
// pe_elastic_fifo: small operand FIFO; a push while full is refused even if a pop happens that cycle.
module pe_elastic_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    dout = mem_q[rd_q[AW-1:0]];
    mem_d = mem_q;
    if (push && !full) mem_d[wr_q[AW-1:0]] = din;
    wr_d = wr_q + (AW+1)'(push && !full);
    rd_d = rd_q + (AW+1)'(pop && !empty);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/pe_elastic_alu.sv
// pe_elastic_alu: elastic-input ALU BEL with per-channel FIFOs, registered output and accumulate mode.
module pe_elastic_alu import pe_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = PE_NUM_DIRS,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 8,
  localparam int SEL_W = $clog2(NUM_INPUTS + 1)
) (
  input  logic                             UserCLK,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic [2:0]                       cfg_op,
  input  logic [SEL_W-1:0]                 cfg_src_a,
  input  logic [SEL_W-1:0]                 cfg_src_b,
  input  logic [DATA_WIDTH-1:0]            cfg_const,
  input  logic                             cfg_acc_en,
  input  logic [CNT_WIDTH-1:0]             cfg_acc_len
);
  localparam int SH_W = $clog2(DATA_WIDTH);
  logic [NUM_INPUTS-1:0] push, pop, full, empty;
  logic [DATA_WIDTH-1:0] head [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] a_val, b_val, res, acc_q, acc_d, out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, last;
  logic a_avail, b_avail, slot_free, at_last, fire, emit, out_valid_q, out_valid_d;
  genvar i;
  for (i = 0; i < NUM_INPUTS; i++) begin : g_ch
    pe_elastic_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(UserCLK), .rst(rst), .push(push[i]), .pop(pop[i]),
      .din(in_data[i*DATA_WIDTH +: DATA_WIDTH]), .dout(head[i]), .full(full[i]), .empty(empty[i]));
  end
  assign in_ready = rst ? '0 : ~full;
  assign push = in_valid & in_ready;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  always_comb begin
    a_val = cfg_const;
    a_avail = 1'b1;
    b_val = cfg_const;
    b_avail = 1'b1;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      if (cfg_src_a == SEL_W'(j)) begin
        a_val = head[j];
        a_avail = !empty[j];
      end
      if (cfg_src_b == SEL_W'(j)) begin
        b_val = head[j];
        b_avail = !empty[j];
      end
    end
    slot_free = !out_valid_q || out_ready;
    last = cfg_acc_len == '0 ? '0 : cfg_acc_len - CNT_WIDTH'(1);
    at_last = cnt_q == last;
    // Partial accumulation steps need no output slot; only the final fold does.
    fire = cfg_acc_en ? a_avail && (!at_last || slot_free) : a_avail && b_avail && slot_free;
    emit = fire && (!cfg_acc_en || at_last);
    res = DATA_WIDTH'(pe_alu(pe_op_t'(cfg_op), pe_word_t'(cfg_acc_en ? acc_q : a_val),
                             pe_word_t'(cfg_acc_en ? a_val : b_val), SH_W));
    pop = '0;
    for (int j = 0; j < NUM_INPUTS; j++)
      pop[j] = fire && (cfg_src_a == SEL_W'(j) || (!cfg_acc_en && cfg_src_b == SEL_W'(j)));
    out_valid_d = emit || (out_valid_q && !out_ready);
    out_data_d = emit ? res : out_data_q;
    acc_d = fire && cfg_acc_en ? (at_last ? cfg_const : res) : acc_q;
    cnt_d = fire && cfg_acc_en ? (at_last ? '0 : cnt_q + CNT_WIDTH'(1)) : cnt_q;
  end
  always_ff @(posedge UserCLK) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      acc_q <= cfg_const;
      cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pe_elastic_alu.sv
// tb_pe_elastic_alu: directed vector table, multi-cycle corner sequences and randomized scoreboard run.
module tb_pe_elastic_alu;
  import pe_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [127:0] in_data = '0;
  logic [3:0] in_valid = '0;
  logic [3:0] in_ready;
  logic [31:0] out_data;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [2:0] cfg_op = 3'd0, cfg_src_a = 3'd0, cfg_src_b = 3'd1;
  logic [31:0] cfg_const = '0;
  logic cfg_acc_en = 1'b0;
  logic [7:0] cfg_acc_len = '0;
  int n_vec = 0, n_err = 0;
  bit sb_en = 1'b0;

  pe_elastic_alu dut (
    .UserCLK(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .cfg_op(cfg_op),
    .cfg_src_a(cfg_src_a), .cfg_src_b(cfg_src_b), .cfg_const(cfg_const),
    .cfg_acc_en(cfg_acc_en), .cfg_acc_len(cfg_acc_len));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op, sa, sb;
    logic [31:0] k, a, b, exp;
  } vec_t;
  vec_t vt[14];

  typedef logic [31:0] q_t [$];
  q_t mq [4];
  logic [31:0] exp_q [$];
  logic [31:0] ma, mb, mr, held_data;
  int le;
  bit held = 1'b0;

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x * y;
      3'd3: return x & y;
      3'd4: return x | y;
      3'd5: return x ^ y;
      3'd6: return x << y[4:0];
      default: return x;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic set_cfg(input logic [2:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [31:0] k, input logic ae, input logic [7:0] len);
    rst = 1'b1;
    in_valid = '0;
    cfg_op = op;
    cfg_src_a = sa;
    cfg_src_b = sb;
    cfg_const = k;
    cfg_acc_en = ae;
    cfg_acc_len = len;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_ch0(input logic [31:0] v);
    in_data[31:0] = v;
    in_valid = 4'b0001;
    @(posedge clk);
    #1 in_valid = '0;
  endtask

  // Scoreboard: operand streams per channel, expected results derived from whole groups.
  always @(negedge clk) if (sb_en) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, held_data);
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rand_extra: got %h required no output", out_data);
        end else check("rand_out", out_data, exp_q.pop_front());
      end
      for (int i = 0; i < 4; i++)
        if (in_valid[i] && in_ready[i]) mq[i].push_back(in_data[i*32 +: 32]);
      if (!cfg_acc_en) begin
        while (mq[cfg_src_a].size() > 0 && (cfg_src_b == 3'd4 || mq[cfg_src_b].size() > 0)) begin
          ma = mq[cfg_src_a].pop_front();
          if (cfg_src_b == 3'd4) mb = cfg_const;
          else if (cfg_src_b == cfg_src_a) mb = ma;
          else mb = mq[cfg_src_b].pop_front();
          exp_q.push_back(ref_op(cfg_op, ma, mb));
        end
      end else begin
        le = cfg_acc_len == 0 ? 1 : int'(cfg_acc_len);
        while (mq[cfg_src_a].size() >= le) begin
          mr = cfg_const;
          repeat (le) mr = ref_op(cfg_op, mr, mq[cfg_src_a].pop_front());
          exp_q.push_back(mr);
        end
      end
    end
  end

  initial begin
    vt[0]  = '{3'd0, 3'd0, 3'd1, 32'd0, 32'd5, 32'd7, 32'd12};
    vt[1]  = '{3'd1, 3'd0, 3'd1, 32'd0, 32'd3, 32'd5, 32'hFFFF_FFFE};
    vt[2]  = '{3'd2, 3'd2, 3'd2, 32'd0, 32'd9, 32'd9, 32'd81};
    vt[3]  = '{3'd6, 3'd3, 3'd4, 32'd4, 32'd1, 32'd0, 32'd16};
    vt[4]  = '{3'd3, 3'd0, 3'd1, 32'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
    vt[5]  = '{3'd4, 3'd1, 3'd2, 32'd0, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF};
    vt[6]  = '{3'd5, 3'd3, 3'd0, 32'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    vt[7]  = '{3'd7, 3'd2, 3'd3, 32'd0, 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF};
    vt[8]  = '{3'd6, 3'd0, 3'd1, 32'd0, 32'd3, 32'd33, 32'd6};
    vt[9]  = '{3'd2, 3'd0, 3'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    vt[10] = '{3'd0, 3'd1, 3'd0, 32'd0, 32'hFFFF_FFFF, 32'd2, 32'd1};
    vt[11] = '{3'd1, 3'd4, 3'd1, 32'd100, 32'd0, 32'd1, 32'd99};
    vt[12] = '{3'd6, 3'd1, 3'd2, 32'd0, 32'h8000_0001, 32'd31, 32'h8000_0000};
    vt[13] = '{3'd5, 3'd0, 3'd4, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0, 32'hEDCB_A987};

    // Reset with every producer asserting valid: nothing may be pushed.
    in_valid = 4'hF;
    in_data = {4{32'hA5A5_0001}};
    @(posedge clk); #1;
    check("rst_ready", 32'(in_ready), 32'h0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    @(posedge clk); #1;
    check("rst_ready2", 32'(in_ready), 32'h0);
    rst = 1'b0;
    in_valid = '0;
    #1 check("post_rst_ready", 32'(in_ready), 32'hF);
    repeat (2) @(posedge clk);
    #1 check("no_push_in_rst", 32'(out_valid), 32'd0);

    foreach (vt[v]) begin
      set_cfg(vt[v].op, vt[v].sa, vt[v].sb, vt[v].k, 1'b0, 8'd0);
      if (vt[v].sa < 3'd4) begin
        in_data[vt[v].sa*32 +: 32] = vt[v].a;
        in_valid[vt[v].sa] = 1'b1;
      end
      if (vt[v].sb < 3'd4 && vt[v].sb != vt[v].sa) begin
        in_data[vt[v].sb*32 +: 32] = vt[v].b;
        in_valid[vt[v].sb] = 1'b1;
      end
      @(posedge clk);
      #1 in_valid = '0;
      check($sformatf("vec%0d_latency", v), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", v), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_data", v), out_data, vt[v].exp);
      @(posedge clk); #1;
      check($sformatf("vec%0d_single", v), 32'(out_valid), 32'd0);
    end

    // Backpressure: three pairs against a stalled output.
    set_cfg(3'd0, 3'd0, 3'd1, 32'd0, 1'b0, 8'd0);
    out_ready = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      in_data[31:0] = 32'(p);
      in_data[63:32] = 32'(p * 10);
      in_valid = 4'b0011;
      @(posedge clk); #1;
    end
    in_valid = '0;
    check("bp_ready", 32'(in_ready), 32'hC);
    for (int c = 0; c < 3; c++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", out_data, 32'd11);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check("bp_first", out_data, 32'd11);
    for (int p = 2; p <= 3; p++) begin
      @(posedge clk); #1;
      check("bp_next_valid", 32'(out_valid), 32'd1);
      check("bp_next_data", out_data, 32'(p * 11));
    end
    @(posedge clk); #1;
    check("bp_drained", 32'(out_valid), 32'd0);

    // Accumulate ADD, length 4, seed 10.
    set_cfg(3'd0, 3'd0, 3'd1, 32'd10, 1'b1, 8'd4);
    for (int p = 1; p <= 4; p++) push_ch0(32'(p));
    check("acc_not_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("acc_valid", 32'(out_valid), 32'd1);
    check("acc_data", out_data, 32'd20);
    @(posedge clk); #1;
    check("acc_single", 32'(out_valid), 32'd0);

    // Length 0 behaves as 1: every operand emitted at full rate.
    set_cfg(3'd0, 3'd0, 3'd1, 32'd10, 1'b1, 8'd0);
    in_data[31:0] = 32'd5;
    in_valid = 4'b0001;
    @(posedge clk); #1;
    in_data[31:0] = 32'd6;
    @(posedge clk); #1;
    check("len0_a", out_data, 32'd15);
    in_data[31:0] = 32'd7;
    @(posedge clk); #1;
    check("len0_b", out_data, 32'd16);
    in_valid = '0;
    @(posedge clk); #1;
    check("len0_c", out_data, 32'd17);
    check("len0_valid", 32'(out_valid), 32'd1);

    // Reset after two of four operands discards the partial sum.
    set_cfg(3'd0, 3'd0, 3'd1, 32'd10, 1'b1, 8'd4);
    push_ch0(32'd1);
    push_ch0(32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    for (int p = 0; p < 4; p++) push_ch0(32'd1);
    check("midrst_not_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("midrst_valid2", 32'(out_valid), 32'd1);
    check("midrst_data", out_data, 32'd14);

    // Randomized traffic against the scoreboard.
    sb_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      set_cfg(3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 4)),
              $urandom, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)));
      for (int t = 0; t < 250; t++) begin
        in_valid = 4'($urandom);
        in_data = {$urandom, $urandom, $urandom, $urandom};
        out_ready = $urandom_range(0, 3) != 0;
        @(posedge clk); #1;
      end
      in_valid = '0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 check("rand_drain", 32'(exp_q.size()), 32'd0);
    end
    sb_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
